ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Sits between ps2_kbd and the cpu keyboard MMIO port. Drains raw PS/2 set-2 bytes from ps2_kbd.
//  Folds E0 (extended) and F0 (break) prefixes into single key events.
//  Buffers the events in a small FIFO, which the cpu pops one event at a time.
// PARAMETERS
//  FIFO_DEPTH  8   event FIFO entries; power of two, >=2
//  EVT_W       10  event width {ext, brk, code[7:0]}; fixed, not overridable
// PORTS
//  clk         in   1      single clock, same domain as ps2_kbd.clk
//  rst         in   1      asynchronous, active-high reset
//  kbd_data    in   8      ps2_kbd data (head byte)
//  kbd_ready   in   1      ps2_kbd has >=1 byte
//  kbd_rdn     out  1      active-low pop strobe to ps2_kbd.rdn, 1-cycle pulse
//  evt_valid   out  1      FIFO non-empty
//  evt_data    out  10     head event {ext, brk, code}; 0 when empty
//  evt_pop     in   1      cpu consumes head event this cycle
//  evt_count   out  $clog2(FIFO_DEPTH)+1  occupancy
//  ovf         out  1      sticky: an event was dropped because the FIFO was full
//  ovf_clr     in   1      clears ovf; a drop in the same cycle wins (ovf stays 1)
// BEHAVIOUR
//  Reset (async, rst=1):
//   - FSM=S_IDLE, kbd_rdn=1, ext=brk=0, FIFO pointers=0.
//   - evt_valid=0, evt_data=0, evt_count=0, ovf=0.
//   - A byte whose pop was already issued is discarded.
//  FSM (one byte per 3 cycles max):
//   - S_IDLE: when kbd_ready=1, latch kbd_data into byte_q, drive kbd_rdn=0 for this cycle, go to S_WAIT.
//   - S_WAIT: kbd_rdn=1 for one cycle so that kbd_ready reflects the pop; go to S_DECODE.
//   - S_DECODE, acting on byte_q, then go to S_IDLE:
//     - 8'hE0: set ext.
//     - 8'hF0: set brk.
//     - 8'h00 / 8'hFF (PS/2 error/overrun): clear ext and brk, no event.
//     - Any other byte: push {ext, brk, byte_q}, clear ext and brk.
//   - The E0 F0 xx sequence yields ext=1, brk=1. F0 E0 xx yields the same result.
//  FIFO:
//   - evt_data is the combinational head, so an event is visible the cycle after the push.
//   - evt_pop while empty is ignored.
//   - Push while full without a pop in the same cycle: drop the event, set ovf, clear ext and brk.
//   - Push and pop in the same cycle while full: both succeed; count unchanged.
//   - Push and pop in the same cycle while empty: the pop is ignored; count becomes 1.
//   - Pointers wrap modulo FIFO_DEPTH. Full/empty is decided by an extra pointer MSB.
//  Latency: kbd_ready high -> evt_valid high = 3 cycles (IDLE, WAIT, DECODE; valid on the next edge).
// CONFIGURATION
//  KBD_TYPEMATIC_FILTER_EN:
//   - Defined: keep last_make {ext, code} and a held flag.
//     - A make event equal to last_make while held is not pushed.
//     - The matching break clears held.
//     - A different make replaces last_make.
//     - Reset clears held.
//   - Undefined: every make event, including typematic repeats, is pushed.
// STRUCTURE
//  Shared package kbd_pkg:
//   - localparams KBD_PFX_EXT=8'hE0, KBD_PFX_BRK=8'hF0, KBD_ERR0=8'h00, KBD_ERR1=8'hFF.
//   - typedef enum kbd_dec_state_t {S_IDLE, S_WAIT, S_DECODE}.
//   - typedef struct packed kbd_evt_t {ext, brk, code[7:0]}.
//  Sub-module kbd_evt_fifo (sync FIFO: push/pop/full/empty/count); the decoder FSM stays in this file.
// TESTING
//  1. Byte 8'h1C (A make) -> kbd_rdn low exactly 1 cycle; 3 cycles later evt_data=10'h01C, count=1.
//  2. Bytes F0,1C -> one event 10'h11C (brk=1); the prefix byte produces no event.
//  3. Bytes E0,F0,75 -> one event 10'h375; ext and brk both clear afterwards.
//     A following 1C gives 10'h01C.
//  4. Fill FIFO_DEPTH events with evt_pop=0, then send 1 more -> ovf=1, count=8, head unchanged.
//     Then ovf_clr=1 -> ovf=0.
//  5. FIFO full; push and evt_pop coincide -> count stays 8, new event at tail, ovf=0.
//     evt_pop on empty -> no change.
//  6. rst pulsed in S_WAIT with ext set, then byte 1C -> event 10'h01C.
//     With KBD_TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C -> events 01C, 11C only.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 set-2 key decoder and its event FIFO.
package kbd_pkg;

    localparam logic [7:0] KBD_PFX_EXT = 8'hE0;
    localparam logic [7:0] KBD_PFX_BRK = 8'hF0;
    localparam logic [7:0] KBD_ERR0    = 8'h00;
    localparam logic [7:0] KBD_ERR1    = 8'hFF;
    localparam int         EVT_W       = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DECODE
    } kbd_dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_evt_t;

endpackage

// File: rtl/kbd_evt_fifo.sv
// Synchronous key-event FIFO; full/empty from an extra pointer MSB, head read combinationally.
module kbd_evt_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  kbd_evt_t                 din,
    input  logic                     pop,
    output logic                     valid,
    output kbd_evt_t                 dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    kbd_evt_t    mem [DEPTH];
    logic        empty;
    logic        full;
    logic        pop_ok;
    logic        push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign count = wr_ptr - rd_ptr;
    assign valid = !empty;
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_key_decoder.sv
// Folds PS/2 set-2 E0/F0 prefixes into {ext, brk, code} events and queues them for the cpu.
// Optional repeat suppression: define KBD_TYPEMATIC_FILTER_EN.
//
//  state    | meaning
//  S_IDLE   | waiting for kbd_ready; pops and latches the head byte
//  S_WAIT   | lets ps2_kbd retire the popped byte
//  S_DECODE | applies byte_q to ext/brk or emits an event
module ps2_key_decoder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    kbd_data,
    input  logic                          kbd_ready,
    output logic                          kbd_rdn,
    output logic                          evt_valid,
    output logic [EVT_W-1:0]              evt_data,
    input  logic                          evt_pop,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    kbd_dec_state_t state, state_nxt;
    logic [7:0]     byte_q;
    logic           ext, ext_nxt;
    logic           brk, brk_nxt;
    logic           latch;
    logic           rdn_c;
    logic           push;
    logic           is_code;
    logic           repeat_hit;
    logic           drop;
    kbd_evt_t       evt_in;
    kbd_evt_t       evt_head;

    assign is_code = !(byte_q == KBD_PFX_EXT || byte_q == KBD_PFX_BRK ||
                       byte_q == KBD_ERR0    || byte_q == KBD_ERR1);
    assign evt_in  = '{ext: ext, brk: brk, code: byte_q};

    always_comb begin
        state_nxt = state;
        ext_nxt   = ext;
        brk_nxt   = brk;
        latch     = 1'b0;
        rdn_c     = 1'b1;
        push      = 1'b0;
        case (state)
            S_IDLE: begin
                if (kbd_ready) begin
                    rdn_c     = 1'b0;
                    latch     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: state_nxt = S_DECODE;
            S_DECODE: begin
                state_nxt = S_IDLE;
                if (byte_q == KBD_PFX_EXT) begin
                    ext_nxt = 1'b1;
                end else if (byte_q == KBD_PFX_BRK) begin
                    brk_nxt = 1'b1;
                end else begin
                    ext_nxt = 1'b0;
                    brk_nxt = 1'b0;
                    push    = is_code && !repeat_hit;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Held high through reset so ps2_kbd never loses a byte to a pop that is about to be discarded.
    assign kbd_rdn = rdn_c | rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            byte_q <= '0;
            ext    <= 1'b0;
            brk    <= 1'b0;
        end else begin
            state <= state_nxt;
            ext   <= ext_nxt;
            brk   <= brk_nxt;
            if (latch) byte_q <= kbd_data;
        end
    end

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic [8:0] last_make;
    logic       held;

    assign repeat_hit = !brk && held && ({ext, byte_q} == last_make);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_make <= '0;
            held      <= 1'b0;
        end else if (state == S_DECODE && is_code) begin
            if (!brk) begin
                last_make <= {ext, byte_q};
                held      <= 1'b1;
            end else if ({ext, byte_q} == last_make) begin
                held <= 1'b0;
            end
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    kbd_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (evt_in),
        .pop   (evt_pop),
        .valid (evt_valid),
        .dout  (evt_head),
        .count (evt_count),
        .drop  (drop)
    );

    assign evt_data = evt_head;

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised bench for ps2_key_decoder with a queue-based event model and directed anchor checks.
module tb_ps2_key_decoder;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_rdn;
    logic       evt_valid;
    logic [9:0] evt_data;
    logic       evt_pop;
    logic [3:0] evt_count;
    logic       ovf;
    logic       ovf_clr;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .kbd_data  (kbd_data),
        .kbd_ready (kbd_ready),
        .kbd_rdn   (kbd_rdn),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_pop   (evt_pop),
        .evt_count (evt_count),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ps2_kbd stand-in: byte queue, head visible after the edge, popped by a low kbd_rdn.
    logic [7:0] kbd_q[$];
    logic       rdn_s = 1'b1;
    int         npops = 0;
    int         nlow  = 0;

    always @(negedge clk) rdn_s = kbd_rdn;

    always @(posedge clk) begin
        #1;
        if (!rdn_s && kbd_q.size() > 0) begin
            void'(kbd_q.pop_front());
            npops++;
        end
        kbd_ready = (kbd_q.size() > 0);
        kbd_data  = (kbd_q.size() > 0) ? kbd_q[0] : 8'h00;
    end

    // Model: decoder occupancy (0 idle, 2 just popped, 1 decoding), prefix flags, event queue, ovf.
    logic [9:0] mq[$];
    int         m_busy = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_ext = 1'b0, m_brk = 1'b0, movf = 1'b0;
    logic       m_held = 1'b0;
    logic [8:0] m_last = '0;

    always @(negedge clk) begin
        logic       push_ev;
        logic [9:0] ev;
        if (rst) begin
            mq.delete();
            m_busy = 0; m_ext = 0; m_brk = 0; movf = 0; m_held = 0; m_last = '0;
            chk("rst_rdn",   {31'd0, kbd_rdn},   32'd1);
            chk("rst_valid", {31'd0, evt_valid}, 32'd0);
            chk("rst_data",  {22'd0, evt_data},  32'd0);
            chk("rst_count", {28'd0, evt_count}, 32'd0);
            chk("rst_ovf",   {31'd0, ovf},       32'd0);
        end else begin
            if (!kbd_rdn) nlow++;
            chk("kbd_rdn",   {31'd0, kbd_rdn},   {31'd0, !(kbd_ready && m_busy == 0)});
            chk("evt_valid", {31'd0, evt_valid}, {31'd0, mq.size() != 0});
            chk("evt_data",  {22'd0, evt_data},  {22'd0, (mq.size() != 0) ? mq[0] : 10'h000});
            chk("evt_count", {28'd0, evt_count}, mq.size());
            chk("ovf",       {31'd0, ovf},       {31'd0, movf});

            push_ev = 1'b0;
            ev      = '0;
            if (m_busy == 1) begin
                m_busy = 0;
                if (m_byte == 8'hE0) m_ext = 1;
                else if (m_byte == 8'hF0) m_brk = 1;
                else if (m_byte == 8'h00 || m_byte == 8'hFF) begin m_ext = 0; m_brk = 0; end
                else begin
                    ev      = {m_ext, m_brk, m_byte};
                    push_ev = 1'b1;
`ifdef KBD_TYPEMATIC_FILTER_EN
                    if (!m_brk) begin
                        if (m_held && m_last == {m_ext, m_byte}) push_ev = 1'b0;
                        m_last = {m_ext, m_byte};
                        m_held = 1'b1;
                    end else if (m_last == {m_ext, m_byte}) begin
                        m_held = 1'b0;
                    end
`endif
                    m_ext = 0; m_brk = 0;
                end
            end else if (m_busy == 2) begin
                m_busy = 1;
            end else if (kbd_ready) begin
                m_byte = kbd_data;
                m_busy = 2;
            end

            if (evt_pop && mq.size() > 0) void'(mq.pop_front());
            if (push_ev && mq.size() >= DEPTH) movf = 1'b1;
            else begin
                if (push_ev) mq.push_back(ev);
                if (ovf_clr) movf = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pop();
        int start = npops;
        int t = 0;
        while (npops == start && t < 100) begin tick(); t++; end
        if (npops == start) chk("pop_timeout", 32'd0, 32'd1);
    endtask

    task automatic settle();
        int t = 0;
        while ((kbd_q.size() != 0 || kbd_ready || m_busy != 0) && t < 1000) begin tick(); t++; end
        if (t >= 1000) chk("settle_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic cpu_pop();
        evt_pop = 1'b1;
        tick();
        evt_pop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int n0;
        rst = 1'b1; kbd_data = 8'h00; kbd_ready = 1'b0; evt_pop = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: single make, rdn pulse width and 3-cycle latency
        n0 = nlow;
        kbd_q.push_back(8'h1C);
        wait_pop();
        tick();
        chk("t1_not_yet_valid", {31'd0, evt_valid}, 32'd0);
        tick();
        chk("t1_valid", {31'd0, evt_valid}, 32'd1);
        chk("t1_data",  {22'd0, evt_data},  32'h01C);
        chk("t1_count", {28'd0, evt_count}, 32'd1);
        chk("t1_rdn_low_cycles", nlow - n0, 32'd1);
        cpu_pop();

        // 2: break prefix
        kbd_q.push_back(8'hF0); kbd_q.push_back(8'h1C);
        settle();
        chk("t2_data",  {22'd0, evt_data},  32'h11C);
        chk("t2_count", {28'd0, evt_count}, 32'd1);
        cpu_pop();

        // 3: extended break, flags cleared afterwards
        kbd_q.push_back(8'hE0); kbd_q.push_back(8'hF0); kbd_q.push_back(8'h75);
        kbd_q.push_back(8'h1C);
        settle();
        chk("t3_data",  {22'd0, evt_data},  32'h375);
        chk("t3_count", {28'd0, evt_count}, 32'd2);
        cpu_pop();
        chk("t3_next",  {22'd0, evt_data},  32'h01C);
        cpu_pop();

        // 4: overflow and clear
        for (int i = 0; i < DEPTH + 1; i++) kbd_q.push_back(8'h15 + 8'(i));
        settle();
        chk("t4_ovf",   {31'd0, ovf},       32'd1);
        chk("t4_count", {28'd0, evt_count}, 32'd8);
        chk("t4_head",  {22'd0, evt_data},  32'h015);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", {31'd0, ovf}, 32'd0);

        // 5: push and pop together while full, then pop on empty
        kbd_q.push_back(8'h33);
        wait_pop();
        tick();
        evt_pop = 1'b1;
        tick();
        evt_pop = 1'b0;
        chk("t5_count", {28'd0, evt_count}, 32'd8);
        chk("t5_ovf",   {31'd0, ovf},       32'd0);
        chk("t5_head",  {22'd0, evt_data},  32'h016);
        for (int i = 0; i < DEPTH - 1; i++) cpu_pop();
        chk("t5_tail",  {22'd0, evt_data},  32'h033);
        cpu_pop();
        evt_pop = 1'b1;
        tick(); tick(); tick();
        evt_pop = 1'b0;
        chk("t5_empty_count", {28'd0, evt_count}, 32'd0);
        chk("t5_empty_valid", {31'd0, evt_valid}, 32'd0);

        // 6: reset while a popped byte is in flight with ext set
        kbd_q.push_back(8'hE0);
        settle();
        kbd_q.push_back(8'h1C);
        wait_pop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        kbd_q.push_back(8'h1C);
        settle();
        chk("t6_data",  {22'd0, evt_data},  32'h01C);
        chk("t6_count", {28'd0, evt_count}, 32'd1);
        cpu_pop();

`ifdef KBD_TYPEMATIC_FILTER_EN
        do_reset();
        kbd_q.push_back(8'h1C); kbd_q.push_back(8'h1C); kbd_q.push_back(8'h1C);
        kbd_q.push_back(8'hF0); kbd_q.push_back(8'h1C);
        settle();
        chk("t6f_count", {28'd0, evt_count}, 32'd2);
        chk("t6f_first", {22'd0, evt_data},  32'h01C);
        cpu_pop();
        chk("t6f_second", {22'd0, evt_data}, 32'h11C);
        cpu_pop();
`endif

        // random traffic; pop rate varies so the FIFO both fills and drains
        for (int phase = 0; phase < 4; phase++) begin
            for (int c = 0; c < 600; c++) begin
                if (kbd_q.size() < 3 && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 11))
                        0, 1:    kbd_q.push_back(8'hE0);
                        2, 3:    kbd_q.push_back(8'hF0);
                        4:       kbd_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
                        5, 6:    kbd_q.push_back(8'h1C);
                        default: kbd_q.push_back(8'($urandom_range(1, 254)));
                    endcase
                end
                evt_pop = ($urandom_range(0, 9) < (phase * 3));
                ovf_clr = ($urandom_range(0, 39) == 0);
                tick();
            end
            evt_pop = 1'b0;
            ovf_clr = 1'b0;
        end
        settle();
        for (int i = 0; i < DEPTH + 2; i++) cpu_pop();
        chk("end_count", {28'd0, evt_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
